fclass_gen: RTL and testbench
=============================

Name: fclass_gen

Overview:
- Inverse of the FPU classify path: takes a 10-bit FCLASS-format class mask plus seed fields and produces a 32-bit IEEE-754 single value that classifies to exactly that mask.
- Used by the float pipeline's special-result builder and by self-check stimulus generation.
- Two-stage pipeline with valid/ready handshake on both sides; full throughput of 1 result per cycle.

Parameters:
- WIDTH, 32, data width of in/out float words; only 32 is supported.
- CNT_W, 8, width of the saturating illegal-mask counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept an input beat this cycle
- in_mask  input  10  class mask. Bit values: 0 -inf, 1 -norm, 2 -sub, 3 -zero, 4 +zero, 5 +sub, 6 +norm, 7 +inf, 8 sNaN, 9 qNaN.
- in_exp  input  8  exponent seed, used by norm classes only
- in_frac  input  23  fraction seed, used by sub, norm and NaN classes
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  generated float
- out_err  output  1  this result came from an illegal (non-one-hot) mask
- err_count  output  CNT_W  saturating count of illegal masks accepted

Behaviour:
- Reset (async, rst=1): all valid flags, out_data, out_err and err_count clear to 0. in_ready is 1 once reset deasserts. Any beat in flight during reset is discarded.
- Input handshake: a beat is accepted when in_valid && in_ready.
- Output handshake: a result is consumed when out_valid && out_ready.
  - out_data and out_err hold stable while out_valid && !out_ready.
- Stage 1 (S1): registers the mask decode (legal flag, sign, class) plus in_exp and in_frac.
  - s1_adv = !s1_valid || s2_adv
- Stage 2 (S2): registers out_data and out_err.
  - s2_adv = !s2_valid || out_ready
- in_ready = s1_adv, a combinational path from out_ready; no bubbles.
- Latency: result appears 2 clocks after the acceptance edge when there is no backpressure.
- Sustained in_valid && out_ready gives 1 result per clock.
- Legal mask: exactly one bit set.
- Illegal mask: zero or multiple bits set.
  - out_data = 0x7FC00000 (canonical qNaN), out_err = 1.
  - err_count increments at S1 acceptance and saturates at 2^CNT_W-1; it never wraps.
- Encoding, with s the sign from the mask:
  - ±inf: {s, 8'hFF, 23'd0}
  - ±zero: {s, 8'h00, 23'd0}
  - ±sub: {s, 8'h00, f}, where f = in_frac, or 23'd1 if in_frac == 0
  - ±norm: {s, e, in_frac}, where e = in_exp clamped: 0 → 1, 0xFF → 0xFE, otherwise unchanged
  - sNaN: {0, 8'hFF, 1'b0, p}, where p = in_frac[21:0], or 22'd1 if that is 0
  - qNaN: {0, 8'hFF, 1'b1, in_frac[21:0]}
- Invariant: every legal-mask output, when classified, returns exactly in_mask.
- Simultaneous accept and consume in the same cycle: both occur, the pipeline shifts, and no beat is lost or duplicated.
- Full pipeline with out_ready=0: in_ready=0. Two beats are held, one in S1 and one in S2.

Test Plan:
- Reset mid-stream: two beats in flight, assert rst asynchronously → out_valid=0 immediately, err_count=0; after release in_ready=1 and no stale result emerges.
- Each legal class with in_frac=0, in_exp=0, out_ready=1 → outputs are, in order:
  - -inf: 0xFF800000
  - -norm: 0x80800000
  - -sub: 0x80000001
  - -zero: 0x80000000
  - +zero: 0x00000000
  - +sub: 0x00000001
  - +norm: 0x00800000
  - +inf: 0x7F800000
  - sNaN: 0x7F800001
  - qNaN: 0x7FC00000
  - each appears 2 cycles after acceptance; classify(out_data) == in_mask.
- Seed clamping: +norm with in_exp=0xFF, in_frac=0x7FFFFF → 0x7F7FFFFF. qNaN with in_frac=0x2AAAAA → 0x7FEAAAAA.
- Illegal masks 0x000 then 0x003 → both produce out_data=0x7FC00000 with out_err=1, err_count=2. Then 300 further illegal beats → err_count saturates at 255.
- Backpressure: stream 5 beats with out_ready held 0 for 4 cycles → in_ready drops after 2 accepted beats, out_data stays stable. Release → all 5 results arrive in order with none dropped or duplicated.
- Random one-hot masks with random seeds and random out_ready (10k beats) → scoreboard match, and the classify round-trip holds for every beat.

Source files
------------

// File: rtl/fclass_gen_if.sv
// Handshake and data bundle for the FCLASS-mask-to-float generator.
interface fclass_gen_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_mask;
  logic [7:0]       in_exp;
  logic [22:0]      in_frac;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_mask, in_exp, in_frac, out_ready,
    input  in_ready, out_valid, out_data, out_err, err_count
  );

  modport slave (
    input  in_valid, in_mask, in_exp, in_frac, out_ready,
    output in_ready, out_valid, out_data, out_err, err_count
  );
endinterface

// File: rtl/fclass_gen.sv
// Builds an IEEE-754 single whose FCLASS mask equals the requested one-hot mask.
// Two-stage valid/ready pipeline: S1 holds the decoded mask, S2 the encoded float.
module fclass_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst,
  fclass_gen_if.slave bus
);

  typedef enum logic [2:0] {
    CLS_INF, CLS_ZERO, CLS_SUB, CLS_NORM, CLS_SNAN, CLS_QNAN
  } cls_e;

  localparam logic [WIDTH-1:0] CANON_QNAN = 32'h7FC0_0000;

  logic             s1_valid_q, s1_legal_q, s1_sign_q;
  cls_e             s1_cls_q;
  logic [7:0]       s1_exp_q;
  logic [22:0]      s1_frac_q;
  logic             s2_valid_q, s2_err_q;
  logic [WIDTH-1:0] s2_data_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic             s1_adv, s2_adv, in_fire;
  logic             dec_legal, dec_sign;
  cls_e             dec_cls;
  logic [7:0]       norm_exp;
  logic [22:0]      sub_frac;
  logic [21:0]      snan_pay;
  logic [WIDTH-1:0] enc_d;

  // in_ready looks through both stages so a consuming sink never sees a bubble.
  assign s2_adv  = !s2_valid_q || bus.out_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign in_fire = bus.in_valid && s1_adv;

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    dec_legal = $onehot(bus.in_mask);
    dec_sign  = |bus.in_mask[3:0];
    dec_cls   = CLS_QNAN;
    if (bus.in_mask[0] || bus.in_mask[7])      dec_cls = CLS_INF;
    else if (bus.in_mask[3] || bus.in_mask[4]) dec_cls = CLS_ZERO;
    else if (bus.in_mask[2] || bus.in_mask[5]) dec_cls = CLS_SUB;
    else if (bus.in_mask[1] || bus.in_mask[6]) dec_cls = CLS_NORM;
    else if (bus.in_mask[8])                   dec_cls = CLS_SNAN;
  end

  // Seeds are nudged just enough to stay inside the requested class.
  always_comb begin
    norm_exp = s1_exp_q;
    if (s1_exp_q == 8'h00)      norm_exp = 8'h01;
    else if (s1_exp_q == 8'hFF) norm_exp = 8'hFE;
    sub_frac = (s1_frac_q == 23'd0) ? 23'd1 : s1_frac_q;
    snan_pay = (s1_frac_q[21:0] == 22'd0) ? 22'd1 : s1_frac_q[21:0];

    enc_d = CANON_QNAN;
    if (s1_legal_q) begin
      unique case (s1_cls_q)
        CLS_INF:  enc_d = {s1_sign_q, 8'hFF, 23'd0};
        CLS_ZERO: enc_d = {s1_sign_q, 8'h00, 23'd0};
        CLS_SUB:  enc_d = {s1_sign_q, 8'h00, sub_frac};
        CLS_NORM: enc_d = {s1_sign_q, norm_exp, s1_frac_q};
        CLS_SNAN: enc_d = {1'b0, 8'hFF, 1'b0, snan_pay};
        CLS_QNAN: enc_d = {1'b0, 8'hFF, 1'b1, s1_frac_q[21:0]};
        default:  enc_d = CANON_QNAN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_legal_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= CLS_INF;
      s1_exp_q   <= 8'h00;
      s1_frac_q  <= 23'd0;
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_data_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_legal_q <= dec_legal;
          s1_sign_q  <= dec_sign;
          s1_cls_q   <= dec_cls;
          s1_exp_q   <= bus.in_exp;
          s1_frac_q  <= bus.in_frac;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= enc_d;
          s2_err_q  <= !s1_legal_q;
        end
      end
      if (in_fire && !dec_legal && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_err   = s2_err_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_fclass_gen.sv
// Scoreboard bench for fclass_gen: a driver queues expected results, a negedge monitor checks them.
module tb_fclass_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fclass_gen_if bus ();
  fclass_gen dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [9:0]  mask;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   seen_valid = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [9:0] classify(input logic [31:0] x);
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 23'd0) return x[31] ? 10'h001 : 10'h080;
      return x[22] ? 10'h200 : 10'h100;
    end
    if (x[30:23] == 8'h00) begin
      if (x[22:0] == 23'd0) return x[31] ? 10'h008 : 10'h010;
      return x[31] ? 10'h004 : 10'h020;
    end
    return x[31] ? 10'h002 : 10'h040;
  endfunction

  function automatic logic [31:0] model(input logic [9:0] m, input logic [7:0] e, input logic [22:0] f);
    logic [7:0]  ec;
    logic [22:0] fs;
    logic [21:0] p;
    ec = (e == 8'h00) ? 8'h01 : ((e == 8'hFF) ? 8'hFE : e);
    fs = (f == 23'd0) ? 23'd1 : f;
    p  = (f[21:0] == 22'd0) ? 22'd1 : f[21:0];
    case (m)
      10'h001: return {1'b1, 8'hFF, 23'd0};
      10'h002: return {1'b1, ec, f};
      10'h004: return {1'b1, 8'h00, fs};
      10'h008: return {1'b1, 8'h00, 23'd0};
      10'h010: return 32'h0000_0000;
      10'h020: return {1'b0, 8'h00, fs};
      10'h040: return {1'b0, ec, f};
      10'h080: return 32'h7F80_0000;
      10'h100: return {1'b0, 8'hFF, 1'b0, p};
      10'h200: return {1'b0, 8'hFF, 1'b1, f[21:0]};
      default: return 32'h7FC0_0000;
    endcase
  endfunction

  // Monitor: a result is consumed at the next rising edge when valid && ready at the negedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) seen_valid++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
        if (!e.err) check("classify", {22'd0, classify(bus.out_data)}, {22'd0, e.mask});
        if (e.lat) check("latency", 32'(cyc - e.acc), 32'd2);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [9:0] m, input logic [7:0] e, input logic [22:0] f,
                      input logic [31:0] d, input logic er, input bit lat);
    exp_t x;
    int   budget;
    bit   done;
    budget = 500;
    done   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mask  = m;
    bus.in_exp   = e;
    bus.in_frac  = f;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        x.data = d; x.err = er; x.mask = m; x.acc = cyc; x.lat = lat;
        sb.push_back(x);
        n_acc++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        budget--;
        if (budget == 0) begin
          check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
          done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while ((sb.size() != 0 || bus.out_valid) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  localparam logic [31:0] LEGAL_EXP [10] = '{
    32'hFF80_0000, 32'h8080_0000, 32'h8000_0001, 32'h8000_0000, 32'h0000_0000,
    32'h0000_0001, 32'h0080_0000, 32'h7F80_0000, 32'h7F80_0001, 32'h7FC0_0000
  };
  localparam logic [9:0]  BP_MASK [5] = '{10'h080, 10'h001, 10'h010, 10'h008, 10'h200};
  localparam logic [31:0] BP_EXP  [5] = '{32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000,
                                          32'h8000_0000, 32'h7FC0_0000};

  initial begin
    logic [9:0]  m;
    logic [7:0]  e;
    logic [22:0] f;
    bus.in_valid = 1'b0;
    bus.in_mask  = '0;
    bus.in_exp   = '0;
    bus.in_frac  = '0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    #20 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Each legal class with zero seeds, back to back, no backpressure.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m = 10'd1 << i;
      send(m, 8'h00, 23'd0, LEGAL_EXP[i], 1'b0, 1'b1);
    end
    drain();

    // Seed clamping.
    send(10'h040, 8'hFF, 23'h7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1'b1);
    send(10'h200, 8'h00, 23'h2A_AAAA, 32'h7FEA_AAAA, 1'b0, 1'b1);
    drain();

    // Illegal masks, then counter saturation.
    send(10'h000, 8'h12, 23'h1234, 32'h7FC0_0000, 1'b1, 1'b1);
    send(10'h003, 8'h34, 23'h5678, 32'h7FC0_0000, 1'b1, 1'b1);
    drain();
    check("err_count_2", {24'd0, bus.err_count}, 32'd2);
    for (int i = 0; i < 300; i++) begin
      m = (i % 2 == 0) ? 10'h3FF : 10'h000;
      send(m, 8'h00, 23'd0, 32'h7FC0_0000, 1'b1, 1'b0);
    end
    drain();
    check("err_count_sat", {24'd0, bus.err_count}, 32'd255);

    // Backpressure: 5 beats, sink stalled for 4 cycles once the pipe fills.
    bus.out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(BP_MASK[i], 8'h00, 23'd0, BP_EXP[i], 1'b0, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
          check("bp_hold_data", bus.out_data, 32'h7F80_0000);
        end
        check("bp_accepted", 32'(n_acc), 32'd2);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_all_accepted", 32'(n_acc), 32'd5);

    // Random one-hot masks with random seeds and random sink readiness.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      m = 10'd1 << $urandom_range(0, 9);
      e = 8'($urandom);
      f = 23'($urandom);
      case ($urandom_range(0, 7))
        0: e = 8'h00;
        1: e = 8'hFF;
        2: f = 23'd0;
        default: ;
      endcase
      send(m, e, f, model(m, e, f), 1'b0, 1'b0);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    send(10'h000, 8'h00, 23'd0, 32'h7FC0_0000, 1'b1, 1'b0);
    send(10'h041, 8'h00, 23'd0, 32'h7FC0_0000, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_err_count", {24'd0, bus.err_count}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen_valid = 0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_stale", 32'(seen_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
